// File: rtl/div_nr_seq.sv
// div_nr_seq: sequential non-restoring divider for the datapath ALU.
// Computes quotient (LO) and remainder (HI) of dividend / divisor in WIDTH+2 clocks,
// or in 2 clocks when the divisor is zero. Signed mode truncates toward zero, so the
// remainder takes the sign of the dividend.
//
// Ports
//   clk          rising-edge clock
//   resetn       asynchronous active-low reset
//   start        request, accepted only while idle and not in the done cycle
//   is_signed    two's-complement operands (ignored when SIGNED_EN=0)
//   dividend     numerator, sampled with start
//   divisor      denominator, sampled with start
//   busy         high from the accepting edge until done is asserted
//   done         one-cycle pulse, results valid from this cycle on
//   quotient     registered quotient
//   remainder    registered remainder
//   div_by_zero  registered, set with done when the divisor was zero
module div_nr_seq #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StIter, StFix, StZero} state_e;

  state_e           state;
  logic [WIDTH:0]   acc;     // partial remainder A, signed
  logic [WIDTH-1:0] qreg;    // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] mreg;    // divisor magnitude
  logic [CW-1:0]    count;
  logic             neg_q;
  logic             neg_r;

  logic             op_signed;
  logic             n_neg;
  logic             d_neg;
  logic [WIDTH-1:0] n_abs;
  logic [WIDTH-1:0] d_abs;
  logic [WIDTH:0]   acc_sh;
  logic [WIDTH:0]   acc_step;
  logic [WIDTH:0]   acc_fix;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;

  always_comb begin
    op_signed = SIGNED_EN && is_signed;
    n_neg     = op_signed & dividend[WIDTH-1];
    d_neg     = op_signed & divisor[WIDTH-1];
    // Magnitudes are unsigned WIDTH-bit values, so |MIN| = 2^(WIDTH-1) is exact.
    n_abs     = n_neg ? -dividend : dividend;
    d_abs     = d_neg ? -divisor : divisor;

    // One non-restoring step; WIDTH+1 bits suffice because A stays in [-M, M).
    acc_sh    = {acc[WIDTH-1:0], qreg[WIDTH-1]};
    acc_step  = acc[WIDTH] ? (acc_sh + {1'b0, mreg}) : (acc_sh - {1'b0, mreg});

    acc_fix   = acc[WIDTH] ? (acc + {1'b0, mreg}) : acc;
    q_final   = neg_q ? -qreg : qreg;
    r_final   = neg_r ? -acc_fix[WIDTH-1:0] : acc_fix[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= StIdle;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      count       <= '0;
      acc         <= '0;
      qreg        <= '0;
      mreg        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          // The done cycle is excluded so a request in that cycle is not accepted.
          if (start && !done) begin
            busy  <= 1'b1;
            acc   <= '0;
            mreg  <= d_abs;
            neg_q <= n_neg ^ d_neg;
            neg_r <= n_neg;
            count <= '0;
            if (divisor == '0) begin
              qreg  <= dividend;  // raw value is reported as the remainder
              state <= StZero;
            end else begin
              qreg  <= n_abs;
              state <= StIter;
            end
          end
        end
        StIter: begin
          acc   <= acc_step;
          qreg  <= {qreg[WIDTH-2:0], ~acc_step[WIDTH]};
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            state <= StFix;
          end
        end
        StFix: begin
          quotient    <= q_final;
          remainder   <= r_final;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= StIdle;
        end
        StZero: begin
          quotient    <= '1;
          remainder   <= qreg;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_div_nr_seq.sv
// tb_div_nr_seq: directed bench for div_nr_seq at WIDTH=32 plus a WIDTH=8 sweep against
// an arithmetic model.
module tb_div_nr_seq;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;

  logic        start32 = 1'b0, sgn32 = 1'b0;
  logic [31:0] n32 = '0, d32 = '0;
  logic        busy32, done32, dbz32;
  logic [31:0] quo32, rem32;

  logic        start8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  n8 = '0, d8 = '0;
  logic        busy8, done8, dbz8;
  logic [7:0]  quo8, rem8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  div_nr_seq #(.WIDTH(32), .SIGNED_EN(1'b1)) u_dut32 (
    .clk(clk), .resetn(resetn), .start(start32), .is_signed(sgn32),
    .dividend(n32), .divisor(d32), .busy(busy32), .done(done32),
    .quotient(quo32), .remainder(rem32), .div_by_zero(dbz32)
  );

  div_nr_seq #(.WIDTH(8), .SIGNED_EN(1'b1)) u_dut8 (
    .clk(clk), .resetn(resetn), .start(start8), .is_signed(sgn8),
    .dividend(n8), .divisor(d8), .busy(busy8), .done(done8),
    .quotient(quo8), .remainder(rem8), .div_by_zero(dbz8)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One 32-bit operation. pulse_at >= 0 raises start with 1/1 for one cycle after that many
  // cycles past the accepting edge; it must be ignored.
  task automatic op32(input string tag, input bit sgn, input logic [31:0] n, input logic [31:0] d,
                      input logic [31:0] eq, input logic [31:0] er, input bit edbz,
                      input int elat, input int pulse_at);
    logic [31:0] q0, r0;
    bit busy_ok, hold_ok;
    int cyc;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    cyc = 0;
    @(posedge clk); #1;
    start32 = 1'b1; sgn32 = sgn; n32 = n; d32 = d;
    @(posedge clk); #1;               // accepting edge k
    start32 = 1'b0; n32 = ~n; d32 = ~d; sgn32 = ~sgn;  // operands must already be latched
    check_eq({tag, ".busy_k"}, busy32, 1'b1);
    q0 = quo32;
    r0 = rem32;
    while (!done32 && cyc < 60) begin
      if (cyc == pulse_at) begin
        start32 = 1'b1; n32 = 32'd1; d32 = 32'd1;
      end else begin
        start32 = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (!done32) begin
        if (!busy32) busy_ok = 1'b0;
        if (quo32 !== q0 || rem32 !== r0) hold_ok = 1'b0;
      end
    end
    start32 = 1'b0;
    check_eq({tag, ".lat"}, cyc, elat);
    check_eq({tag, ".busy_held"}, busy_ok, 1'b1);
    check_eq({tag, ".out_held"}, hold_ok, 1'b1);
    check_eq({tag, ".busy_done"}, busy32, 1'b0);
    check_eq({tag, ".q"}, quo32, eq);
    check_eq({tag, ".r"}, rem32, er);
    check_eq({tag, ".dbz"}, dbz32, edbz);
    // Request raised during the done cycle must not be accepted.
    start32 = 1'b1; n32 = 32'd1; d32 = 32'd1;
    @(posedge clk); #1;
    start32 = 1'b0;
    check_eq({tag, ".done_pulse"}, done32, 1'b0);
    check_eq({tag, ".no_accept"}, busy32, 1'b0);
  endtask

  function automatic void model8(input bit sgn, input logic [7:0] n, input logic [7:0] d,
                                 output logic [7:0] q, output logic [7:0] r, output bit z);
    int ni, di;
    z = 1'b0;
    if (d == 8'd0) begin
      q = 8'hFF; r = n; z = 1'b1;
    end else if (sgn) begin
      ni = int'($signed(n));
      di = int'($signed(d));
      q  = 8'(ni / di);
      r  = 8'(ni % di);
    end else begin
      q = n / d;
      r = n % d;
    end
  endfunction

  task automatic op8(input bit sgn, input logic [7:0] n, input logic [7:0] d);
    logic [7:0] eq, er;
    bit ez;
    int cyc;
    model8(sgn, n, d, eq, er, ez);
    cyc = 0;
    @(posedge clk); #1;
    start8 = 1'b1; sgn8 = sgn; n8 = n; d8 = d;
    @(posedge clk); #1;
    start8 = 1'b0;
    while (!done8 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq($sformatf("w8 %0d %0h/%0h lat", sgn, n, d), cyc, ez ? 1 : 9);
    check_eq($sformatf("w8 %0d %0h/%0h q", sgn, n, d), quo8, eq);
    check_eq($sformatf("w8 %0d %0h/%0h r", sgn, n, d), rem8, er);
    check_eq($sformatf("w8 %0d %0h/%0h dbz", sgn, n, d), dbz8, ez);
    if (!ez) check_eq($sformatf("w8 %0d %0h/%0h qd+r", sgn, n, d), 8'(quo8 * d + rem8), n);
  endtask

  logic [7:0] vals [12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h40,
                            8'h55, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};

  initial begin
    #2;
    check_eq("rst.busy", busy32, 1'b0);
    check_eq("rst.done", done32, 1'b0);
    check_eq("rst.q", quo32, 32'h0);
    check_eq("rst.r", rem32, 32'h0);
    check_eq("rst.dbz", dbz32, 1'b0);
    #20 resetn = 1'b1;

    op32("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, -1);
    op32("s-7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33, -1);
    op32("s7_-2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, 33, -1);
    op32("s-7_-2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b0, 33, -1);
    op32("s100_7", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, -1);
    op32("u5_0", 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1, 0);
    op32("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, -1);
    op32("s5_0", 1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1, -1);
    op32("s-5_0", 1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1, -1);
    op32("smin_-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 33, -1);
    op32("umin_max", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 33, -1);
    op32("u3_10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 33, -1);
    op32("umax_1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 33, -1);
    op32("umax_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 33, -1);
    op32("u_hex", 1'b0, 32'h12345678, 32'h00001000, 32'h00012345, 32'h00000678, 1'b0, 33, -1);
    op32("pulse10", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 10);
    op32("pulse_fix", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 32);

    // Reset in the middle of an operation.
    @(posedge clk); #1;
    start32 = 1'b1; sgn32 = 1'b0; n32 = 32'd100; d32 = 32'd7;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (20) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    check_eq("abort.busy", busy32, 1'b0);
    check_eq("abort.done", done32, 1'b0);
    check_eq("abort.q", quo32, 32'h0);
    check_eq("abort.r", rem32, 32'h0);
    check_eq("abort.dbz", dbz32, 1'b0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check_eq("abort.no_done", done32, 1'b0);
    check_eq("abort.idle", busy32, 1'b0);
    op32("after_rst", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, -1);

    // WIDTH=8 boundary grid in both modes, then random pairs.
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 12; i++)
        for (int j = 0; j < 12; j++)
          op8(s[0], vals[i], vals[j]);
    for (int k = 0; k < 300; k++)
      op8(1'($urandom_range(1)), 8'($urandom_range(255)), 8'($urandom_range(255)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
